// File: rtl/cheri_tag_pkg.sv
// Shared types and constants for the CHERI capability-tag request path.
package cheri_tag_pkg;

   localparam int unsigned TAG_PORT_ICACHE = 0;
   localparam int unsigned TAG_PORT_DLOAD  = 1;
   localparam int unsigned TAG_PORT_DSTORE = 2;

   localparam int unsigned TAG_NR_PORTS   = TAG_PORT_DSTORE + 1;
   localparam int unsigned TAG_ADDR_WIDTH = 64;
   localparam int unsigned TAG_TAG_WIDTH  = 1;
   localparam int unsigned TAG_TID_WIDTH  = 2;

   typedef struct packed {
      logic [TAG_ADDR_WIDTH-1:0] addr;
      logic                      we;
      logic [TAG_TAG_WIDTH-1:0]  wtag;
   } tag_req_t;

   typedef struct packed {
      logic [TAG_TID_WIDTH-1:0] tid;
      logic [TAG_TAG_WIDTH-1:0] rtag;
   } tag_rsp_t;

   // Width of a port index; never zero so a single-port build still has a legal vector.
   function automatic int unsigned idx_width(int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cheri_tag_tid_alloc.sv
// Transaction-ID bookkeeping: busy bitmap, owner table, lowest-free selection and
// detection of responses that arrive for a TID nobody holds.
module cheri_tag_tid_alloc
   import cheri_tag_pkg::*;
#(
   parameter int unsigned NR_PORTS  = TAG_NR_PORTS,
   parameter int unsigned TID_WIDTH = TAG_TID_WIDTH,
   parameter int unsigned PORT_W    = idx_width(NR_PORTS)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 alloc_i,
   input  logic [TID_WIDTH-1:0] alloc_tid_i,
   input  logic [PORT_W-1:0]    alloc_port_i,
   input  logic                 rsp_valid_i,
   input  logic [TID_WIDTH-1:0] rsp_tid_i,
   output logic                 cand_valid_o,
   output logic [TID_WIDTH-1:0] cand_tid_o,
   output logic                 hit_o,
   output logic [PORT_W-1:0]    hit_port_o,
   output logic                 busy_any_o,
   output logic                 err_o
);

   localparam int unsigned MAX_OUT = 2 ** TID_WIDTH;

   logic [MAX_OUT-1:0]             busy_q, busy_d;
   logic [MAX_OUT-1:0][PORT_W-1:0] owner_q, owner_d;
   logic                           err_q;

   // Descending scan so the lowest free index is the last one written.
   always_comb begin
      cand_valid_o = 1'b0;
      cand_tid_o   = '0;
      for (int i = MAX_OUT - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            cand_valid_o = 1'b1;
            cand_tid_o   = TID_WIDTH'(i);
         end
      end
   end

   assign hit_o      = rsp_valid_i & busy_q[rsp_tid_i];
   assign hit_port_o = owner_q[rsp_tid_i];
   assign busy_any_o = |busy_q;
   assign err_o      = err_q;

   always_comb begin
      busy_d  = busy_q;
      owner_d = owner_q;
      if (alloc_i) begin
         busy_d[alloc_tid_i]  = 1'b1;
         owner_d[alloc_tid_i] = alloc_port_i;
      end
      if (hit_o) begin
         busy_d[rsp_tid_i] = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q  <= '0;
         owner_q <= '0;
         err_q   <= 1'b0;
      end else begin
         busy_q  <= busy_d;
         owner_q <= owner_d;
         if (rsp_valid_i && !busy_q[rsp_tid_i]) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/cheri_tag_req_arbiter.sv
// Round-robin arbiter sharing the tag-memory port between the cache requesters;
// out-of-order responses are routed back by transaction ID.
module cheri_tag_req_arbiter
   import cheri_tag_pkg::*;
#(
   parameter int unsigned NR_PORTS   = TAG_NR_PORTS,
   parameter int unsigned ADDR_WIDTH = TAG_ADDR_WIDTH,
   parameter int unsigned TAG_WIDTH  = TAG_TAG_WIDTH,
   parameter int unsigned TID_WIDTH  = TAG_TID_WIDTH
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NR_PORTS-1:0]                 req_valid_i,
   output logic [NR_PORTS-1:0]                 req_ready_o,
   input  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0] req_addr_i,
   input  logic [NR_PORTS-1:0]                 req_we_i,
   input  logic [NR_PORTS-1:0][TAG_WIDTH-1:0]  req_wtag_i,
   output logic [NR_PORTS-1:0]                 rsp_valid_o,
   output logic [TAG_WIDTH-1:0]                rsp_rtag_o,
   output logic                                mem_req_valid_o,
   input  logic                                mem_req_ready_i,
   output logic [ADDR_WIDTH-1:0]               mem_req_addr_o,
   output logic                                mem_req_we_o,
   output logic [TAG_WIDTH-1:0]                mem_req_wtag_o,
   output logic [TID_WIDTH-1:0]                mem_req_tid_o,
   input  logic                                mem_rsp_valid_i,
   input  logic [TID_WIDTH-1:0]                mem_rsp_tid_i,
   input  logic [TAG_WIDTH-1:0]                mem_rsp_rtag_i,
   output logic                                idle_o,
   output logic                                err_o
);

   localparam int unsigned PORT_W = idx_width(NR_PORTS);

   logic [PORT_W-1:0]    rr_q, lock_port_q;
   logic                 lock_q;
   logic [TID_WIDTH-1:0] lock_tid_q;

   logic                 w_cand_valid, w_hit, w_busy_any, w_hs;
   logic [TID_WIDTH-1:0] w_cand_tid;
   logic [PORT_W-1:0]    w_hit_port, w_rr_win, w_win;

   cheri_tag_tid_alloc #(
      .NR_PORTS  (NR_PORTS),
      .TID_WIDTH (TID_WIDTH),
      .PORT_W    (PORT_W)
   ) u_tid_alloc (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .alloc_i      (w_hs),
      .alloc_tid_i  (mem_req_tid_o),
      .alloc_port_i (w_win),
      .rsp_valid_i  (mem_rsp_valid_i),
      .rsp_tid_i    (mem_rsp_tid_i),
      .cand_valid_o (w_cand_valid),
      .cand_tid_o   (w_cand_tid),
      .hit_o        (w_hit),
      .hit_port_o   (w_hit_port),
      .busy_any_o   (w_busy_any),
      .err_o        (err_o)
   );

   // First valid port at or after rr_q; descending offsets leave the nearest one.
   always_comb begin
      w_rr_win = rr_q;
      for (int i = NR_PORTS - 1; i >= 0; i--) begin
         if (req_valid_i[(int'(rr_q) + i) % int'(NR_PORTS)]) begin
            w_rr_win = PORT_W'((int'(rr_q) + i) % int'(NR_PORTS));
         end
      end
   end

   // A stalled grant keeps its port and TID even if a lower TID frees up meanwhile.
   assign w_win           = lock_q ? lock_port_q : w_rr_win;
   assign mem_req_valid_o = w_cand_valid & (lock_q | (|req_valid_i));
   assign mem_req_tid_o   = lock_q ? lock_tid_q : w_cand_tid;
   assign mem_req_addr_o  = req_addr_i[w_win];
   assign mem_req_we_o    = req_we_i[w_win];
   assign mem_req_wtag_o  = req_wtag_i[w_win];
   assign w_hs            = mem_req_valid_o & mem_req_ready_i;

   always_comb begin
      req_ready_o = '0;
      rsp_valid_o = '0;
      if (mem_req_valid_o) begin
         req_ready_o[w_win] = mem_req_ready_i;
      end
      if (w_hit) begin
         rsp_valid_o[w_hit_port] = 1'b1;
      end
   end

   assign rsp_rtag_o = w_hit ? mem_rsp_rtag_i : '0;
   assign idle_o     = !w_busy_any && !(|req_valid_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q        <= '0;
         lock_q      <= 1'b0;
         lock_port_q <= '0;
         lock_tid_q  <= '0;
      end else if (w_hs) begin
         rr_q   <= (int'(w_win) == int'(NR_PORTS) - 1) ? '0 : w_win + PORT_W'(1);
         lock_q <= 1'b0;
      end else if (mem_req_valid_o) begin
         lock_q      <= 1'b1;
         lock_port_q <= w_win;
         lock_tid_q  <= mem_req_tid_o;
      end
   end

endmodule

// File: tb/tb_cheri_tag_req_arbiter.sv
// Directed bench for the tag-request arbiter with hand-computed expectations.
module tb_cheri_tag_req_arbiter;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic [2:0]        req_valid_i;
   logic [2:0]        req_ready_o;
   logic [2:0][63:0]  req_addr_i;
   logic [2:0]        req_we_i;
   logic [2:0][0:0]   req_wtag_i;
   logic [2:0]        rsp_valid_o;
   logic [0:0]        rsp_rtag_o;
   logic              mem_req_valid_o;
   logic              mem_req_ready_i;
   logic [63:0]       mem_req_addr_o;
   logic              mem_req_we_o;
   logic [0:0]        mem_req_wtag_o;
   logic [1:0]        mem_req_tid_o;
   logic              mem_rsp_valid_i;
   logic [1:0]        mem_rsp_tid_i;
   logic [0:0]        mem_rsp_rtag_i;
   logic              idle_o;
   logic              err_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_i = ~clk_i;

   cheri_tag_req_arbiter dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_addr_i      (req_addr_i),
      .req_we_i        (req_we_i),
      .req_wtag_i      (req_wtag_i),
      .rsp_valid_o     (rsp_valid_o),
      .rsp_rtag_o      (rsp_rtag_o),
      .mem_req_valid_o (mem_req_valid_o),
      .mem_req_ready_i (mem_req_ready_i),
      .mem_req_addr_o  (mem_req_addr_o),
      .mem_req_we_o    (mem_req_we_o),
      .mem_req_wtag_o  (mem_req_wtag_o),
      .mem_req_tid_o   (mem_req_tid_o),
      .mem_rsp_valid_i (mem_rsp_valid_i),
      .mem_rsp_tid_i   (mem_rsp_tid_i),
      .mem_rsp_rtag_i  (mem_rsp_rtag_i),
      .idle_o          (idle_o),
      .err_o           (err_o)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are changed here.
   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_ni          = 1'b0;
      req_valid_i     = '0;
      req_addr_i      = '0;
      req_we_i        = '0;
      req_wtag_i      = '0;
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b0;
      mem_rsp_tid_i   = '0;
      mem_rsp_rtag_i  = '0;
      repeat (2) cyc();
      #1;
      chk("rst_idle", 64'(idle_o), 64'd1);
      chk("rst_err", 64'(err_o), 64'd0);
      chk("rst_mvalid", 64'(mem_req_valid_o), 64'd0);
      chk("rst_rsp", 64'(rsp_valid_o), 64'd0);
      chk("rst_ready", 64'(req_ready_o), 64'd0);
      cyc();
      rst_ni = 1'b1;

      // Round robin across all three ports, TIDs 0..2.
      cyc();
      req_addr_i[0] = 64'h100; req_addr_i[1] = 64'h200; req_addr_i[2] = 64'h300;
      req_valid_i = 3'b111; mem_req_ready_i = 1'b1;
      #1;
      chk("rr0_valid", 64'(mem_req_valid_o), 64'd1);
      chk("rr0_tid", 64'(mem_req_tid_o), 64'd0);
      chk("rr0_addr", mem_req_addr_o, 64'h100);
      chk("rr0_ready", 64'(req_ready_o), 64'b001);
      chk("rr0_idle", 64'(idle_o), 64'd0);
      cyc(); req_valid_i = 3'b110; #1;
      chk("rr1_tid", 64'(mem_req_tid_o), 64'd1);
      chk("rr1_addr", mem_req_addr_o, 64'h200);
      chk("rr1_ready", 64'(req_ready_o), 64'b010);
      cyc(); req_valid_i = 3'b100; #1;
      chk("rr2_tid", 64'(mem_req_tid_o), 64'd2);
      chk("rr2_ready", 64'(req_ready_o), 64'b100);

      // Out-of-order responses: TID 1 (port 1), TID 0 (port 0), TID 2 (port 2).
      cyc(); req_valid_i = '0;
      mem_rsp_valid_i = 1'b1; mem_rsp_tid_i = 2'd1; mem_rsp_rtag_i = 1'b1; #1;
      chk("ooo1_rsp", 64'(rsp_valid_o), 64'b010);
      chk("ooo1_rtag", 64'(rsp_rtag_o), 64'd1);
      chk("ooo1_mvalid", 64'(mem_req_valid_o), 64'd0);
      cyc(); mem_rsp_tid_i = 2'd0; mem_rsp_rtag_i = 1'b0; #1;
      chk("ooo0_rsp", 64'(rsp_valid_o), 64'b001);
      chk("ooo0_rtag", 64'(rsp_rtag_o), 64'd0);
      cyc(); mem_rsp_tid_i = 2'd2; mem_rsp_rtag_i = 1'b1; #1;
      chk("ooo2_rsp", 64'(rsp_valid_o), 64'b100);
      cyc(); mem_rsp_valid_i = 1'b0; #1;
      chk("ooo_idle", 64'(idle_o), 64'd1);

      // Exhaust all four TIDs from port 1.
      cyc(); req_valid_i = 3'b010; req_addr_i[1] = 64'h1000; #1;
      chk("fill_tid0", 64'(mem_req_tid_o), 64'd0);
      chk("fill_ready0", 64'(req_ready_o), 64'b010);
      for (int k = 1; k < 4; k++) begin
         cyc(); req_addr_i[1] = 64'h1000 + 64'(k); #1;
         chk($sformatf("fill_tid%0d", k), 64'(mem_req_tid_o), 64'(k));
      end
      cyc(); req_addr_i[1] = 64'h1004; #1;
      chk("full_mvalid", 64'(mem_req_valid_o), 64'd0);
      chk("full_ready", 64'(req_ready_o), 64'b000);
      cyc(); #1;
      chk("full_ready2", 64'(req_ready_o), 64'b000);
      cyc(); mem_rsp_valid_i = 1'b1; mem_rsp_tid_i = 2'd2; mem_rsp_rtag_i = 1'b0; #1;
      chk("free2_rsp", 64'(rsp_valid_o), 64'b010);
      chk("free2_mvalid", 64'(mem_req_valid_o), 64'd0);
      cyc(); mem_rsp_valid_i = 1'b0; #1;
      chk("reuse_mvalid", 64'(mem_req_valid_o), 64'd1);
      chk("reuse_tid", 64'(mem_req_tid_o), 64'd2);
      chk("reuse_addr", mem_req_addr_o, 64'h1004);
      chk("reuse_ready", 64'(req_ready_o), 64'b010);
      cyc(); req_valid_i = '0;
      for (int k = 0; k < 4; k++) begin
         mem_rsp_valid_i = 1'b1; mem_rsp_tid_i = 2'(k); #1;
         chk($sformatf("drain%0d_rsp", k), 64'(rsp_valid_o), 64'b010);
         cyc();
      end
      mem_rsp_valid_i = 1'b0;

      // Stall port 2 for three cycles while port 0 arrives.
      req_valid_i = 3'b100; req_addr_i[2] = 64'hA00; req_we_i = 3'b100;
      req_wtag_i[2] = 1'b1; mem_req_ready_i = 1'b0; #1;
      chk("stall_valid", 64'(mem_req_valid_o), 64'd1);
      chk("stall_tid", 64'(mem_req_tid_o), 64'd0);
      chk("stall_we", 64'(mem_req_we_o), 64'd1);
      chk("stall_wtag", 64'(mem_req_wtag_o), 64'd1);
      chk("stall_ready", 64'(req_ready_o), 64'b000);
      cyc(); req_valid_i = 3'b101; req_addr_i[0] = 64'hB00; #1;
      chk("lock1_addr", mem_req_addr_o, 64'hA00);
      chk("lock1_tid", 64'(mem_req_tid_o), 64'd0);
      chk("lock1_ready", 64'(req_ready_o), 64'b000);
      cyc(); #1;
      chk("lock2_addr", mem_req_addr_o, 64'hA00);
      cyc(); mem_req_ready_i = 1'b1; #1;
      chk("lock3_ready", 64'(req_ready_o), 64'b100);
      chk("lock3_tid", 64'(mem_req_tid_o), 64'd0);
      chk("lock3_addr", mem_req_addr_o, 64'hA00);
      cyc(); req_valid_i = 3'b001; req_we_i = '0; #1;
      chk("after_addr", mem_req_addr_o, 64'hB00);
      chk("after_tid", 64'(mem_req_tid_o), 64'd1);
      chk("after_ready", 64'(req_ready_o), 64'b001);
      chk("after_we", 64'(mem_req_we_o), 64'd0);
      cyc(); req_valid_i = '0;
      mem_rsp_valid_i = 1'b1; mem_rsp_tid_i = 2'd0; mem_rsp_rtag_i = 1'b1; #1;
      chk("own2_rsp", 64'(rsp_valid_o), 64'b100);
      chk("own2_rtag", 64'(rsp_rtag_o), 64'd1);
      cyc(); mem_rsp_tid_i = 2'd1; mem_rsp_rtag_i = 1'b0; #1;
      chk("own0_rsp", 64'(rsp_valid_o), 64'b001);

      // Response to a free TID.
      cyc(); mem_rsp_tid_i = 2'd3; mem_rsp_rtag_i = 1'b1; #1;
      chk("stray_rsp", 64'(rsp_valid_o), 64'b000);
      chk("stray_err_pre", 64'(err_o), 64'd0);
      cyc(); mem_rsp_valid_i = 1'b0; #1;
      chk("stray_err", 64'(err_o), 64'd1);
      cyc(); #1;
      chk("stray_err_sticky", 64'(err_o), 64'd1);
      rst_ni = 1'b0; #1;
      chk("rst2_err", 64'(err_o), 64'd0);
      chk("rst2_idle", 64'(idle_o), 64'd1);
      cyc(); rst_ni = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
